elevator_sequencer: RTL and testbench
=====================================

// Module: elevator_sequencer
// PURPOSE
//  Central motion/door sequencer of the 4-storey elevator controller; initiator side of the timer handshakes.
//  Latches floor calls and picks travel direction by SCAN (keep direction while calls lie ahead).
//  Drives StRun (mv2nxt) to the run timer and StOpen (opendoor) to the door timer; consumes endRun/endOpen.
//  Tracks current floor; exports floor, direction and pending calls to display logic.
// PARAMETERS
//  NFLOOR        4    number of floors (floor 0 = ground); floor field is 2 bits
//  HOME_FLOOR    0    floor auto-called when idle (HOME_RETURN_EN only)
//  IDLE_TIMEOUT  40   idle CP cycles before home call (HOME_RETURN_EN only), 1..255
// PORTS
//  CP        in   1  system clock, all state on posedge
//  nCR       in   1  asynchronous active-low reset
//  call_req  in   4  per-floor call (hall OR cab), level, sampled each edge; bit i = floor i
//  endRun    in   1  run timer done; valid only while StRun=1
//  endOpen   in   1  door timer done; valid only while StOpen=1
//  StRun     out  1  move-to-next-floor command, held until endRun seen
//  StOpen    out  1  open-door command, held until endOpen seen
//  floor     out  2  current floor
//  dir_up    out  1  committed direction up
//  dir_dn    out  1  committed direction down (never both 1)
//  pending   out  4  latched, unserved calls
// BEHAVIOUR
//  Reset (nCR=0, async): StRun=0, StOpen=0, floor=0, dir_up=dir_dn=0, pending=0, state=IDLE, idle count=0.
//  All outputs registered. pending[i] set on any edge with call_req[i]=1; set beats clear, except below.
//  States: IDLE, RUN, ARRIVE, OPEN.
//   IDLE:   pending[floor] -> OPEN; else calls above -> dir_up=1, RUN; else calls below -> dir_dn=1, RUN;
//           none -> stay, dir cleared. Above/below tie: up wins.
//   RUN:    StRun=1. Edge with endRun=1: floor+=1 (dir_up) or -=1 (dir_dn), StRun=0 -> ARRIVE.
//   ARRIVE: one cycle, StRun=0 and StOpen=0 (guarantees timer clear). pending[floor] -> OPEN;
//           else calls ahead in dir -> RUN; else calls behind -> reverse dir, RUN; else clear dir -> IDLE.
//   OPEN:   entry clears pending[floor]; StOpen=1. call_req[floor] during OPEN is absorbed (not latched).
//           Edge with endOpen=1: StOpen=0 -> ARRIVE (re-decides; ARRIVE with no calls -> IDLE).
//  StRun and StOpen never both 1; each drops for >=1 cycle between successive commands.
//  Latency: call to current floor in IDLE sampled at edge k -> StOpen=1 after edge k+1.
//   Call elsewhere: StRun=1 after edge k+1. endRun seen at edge m -> floor updated and StRun=0 after edge m.
//  endRun outside RUN, endOpen outside OPEN: ignored. floor stays in 0..3; at floor 3 dir_up never
//   persists into RUN (no calls above), likewise floor 0 / dir_dn.
//  Reset mid-RUN/OPEN: commands drop immediately, so downstream timers return to count 0.
// CONFIGURATION
//  HOME_RETURN_EN defined: 8-bit idle counter increments each cycle in IDLE with pending=0 and
//   floor!=HOME_FLOOR; on reaching IDLE_TIMEOUT sets pending[HOME_FLOOR], counter clears.
//   Counter clears whenever state!=IDLE or pending!=0.
//  Not defined: no counter; elevator parks at last served floor. HOME_FLOOR/IDLE_TIMEOUT unused.
// STRUCTURE
//  elevator_defs.vh (shared include): state codes IDLE=2'd0 RUN=2'd1 ARRIVE=2'd2 OPEN=2'd3,
//   NFLOOR, floor width 2, direction encodings; also used by display decoder.
//  Sub-module elev_call_latch: pending register with set/clear/absorb and above/below/here
//   request flags for the given floor. FSM, floor counter, direction regs stay in top.
// TESTING
//  1 Reset, pulse call_req=4'b0001 at floor 0 -> StOpen=1 two edges later, pending=0; endOpen -> IDLE.
//  2 call_req[3] from floor 0 -> 3 RUN/ARRIVE cycles, floor 0->1->2->3, dir_up=1, then StOpen; never both cmds.
//  3 At floor 1 going up with calls at 3 and 0 -> serves 3 first, reverses dir_dn, serves 0, dirs clear.
//  4 Hold call_req[floor] during OPEN -> no re-latch, no second open; endRun pulsed in OPEN -> ignored.
//  5 Assert nCR low mid-RUN at floor 2 -> StRun=0 same time, floor=0, pending=0; resume from IDLE.
//  6 HOME_RETURN_EN, IDLE_TIMEOUT=4, idle at floor 2 -> pending[0] set after 4 idle cycles, returns to 0.

Source files
------------

// File: rtl/elevator_sequencer_pkg.sv
// elevator_sequencer_pkg: shared state/direction encodings and sizing for the elevator sequencer.
package elevator_sequencer_pkg;
  localparam int NFLOOR = 4;
  localparam int FW = 2;
  localparam int HOME_FLOOR = 0;
  localparam int IDLE_TIMEOUT = 40;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ARRIVE = 2'd2, OPEN = 2'd3} state_e;
  // one-hot so dir_up/dir_dn come straight off the register bits
  typedef enum logic [1:0] {DIR_NONE = 2'b00, DIR_UP = 2'b01, DIR_DN = 2'b10} dir_e;
  function automatic logic [NFLOOR-1:0] floor_bit(input logic [FW-1:0] f);
    return NFLOOR'(1) << f;
  endfunction
endpackage

// File: rtl/elevator_sequencer_call_latch.sv
// elevator_sequencer_call_latch: pending-call register with set/clear/absorb and here/above/below flags.
module elevator_sequencer_call_latch
  import elevator_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NFLOOR-1:0] call_i,
  input  logic [NFLOOR-1:0] set_i,
  input  logic [FW-1:0]     floor_i,
  input  logic              clr_i,
  input  logic              absorb_i,
  output logic [NFLOOR-1:0] pending_o,
  output logic              here_o,
  output logic              above_o,
  output logic              below_o
);
  logic [NFLOOR-1:0] pend_q, pend_d, here_m;
  assign here_m = floor_bit(floor_i);
  // new calls win over clears, except at the floor whose door is opening or open
  assign pend_d = (pend_q & ~(clr_i ? here_m : '0))
                | ((call_i | set_i) & ~((clr_i | absorb_i) ? here_m : '0));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else pend_q <= pend_d;
  end
  always_comb begin
    above_o = 1'b0;
    below_o = 1'b0;
    for (int i = 0; i < NFLOOR; i++) begin
      above_o = above_o | (pend_q[i] & (i > int'(floor_i)));
      below_o = below_o | (pend_q[i] & (i < int'(floor_i)));
    end
  end
  assign here_o = |(pend_q & here_m);
  assign pending_o = pend_q;
endmodule

// File: rtl/elevator_sequencer.sv
// elevator_sequencer: SCAN motion/door sequencer driving the run and door timers.
// Optional HOME_RETURN_EN: auto-call HOME_FLOOR after IDLE_TIMEOUT idle cycles away from it.
module elevator_sequencer
  import elevator_sequencer_pkg::*;
(
  input  logic              CP,
  input  logic              nCR,
  input  logic [NFLOOR-1:0] call_req,
  input  logic              endRun,
  input  logic              endOpen,
  output logic              StRun,
  output logic              StOpen,
  output logic [FW-1:0]     floor,
  output logic              dir_up,
  output logic              dir_dn,
  output logic [NFLOOR-1:0] pending
);
  state_e state_q;
  dir_e dir_q, fwd, rev;
  logic [FW-1:0] floor_q;
  logic run_q, open_q, here, above, below, ahead, behind, open_go;
  logic [NFLOOR-1:0] home_set;
  elevator_sequencer_call_latch u_latch (
    .clk(CP), .rst_n(nCR), .call_i(call_req), .set_i(home_set), .floor_i(floor_q),
    .clr_i(open_go), .absorb_i(state_q == OPEN), .pending_o(pending),
    .here_o(here), .above_o(above), .below_o(below)
  );
  // with no committed direction, "ahead" means up so an above/below tie goes up
  assign ahead = (dir_q == DIR_DN) ? below : above;
  assign behind = (dir_q == DIR_DN) ? above : below;
  assign fwd = (dir_q == DIR_DN) ? DIR_DN : DIR_UP;
  assign rev = (dir_q == DIR_DN) ? DIR_UP : DIR_DN;
  assign open_go = (state_q == IDLE || state_q == ARRIVE) && here;
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_q <= IDLE;
      dir_q <= DIR_NONE;
      floor_q <= '0;
      run_q <= 1'b0;
      open_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ARRIVE: begin
          if (here) begin
            state_q <= OPEN;
            open_q <= 1'b1;
          end else if (ahead) begin
            state_q <= RUN;
            run_q <= 1'b1;
            dir_q <= fwd;
          end else if (behind) begin
            state_q <= RUN;
            run_q <= 1'b1;
            dir_q <= rev;
          end else begin
            state_q <= IDLE;
            dir_q <= DIR_NONE;
          end
        end
        RUN: if (endRun) begin
          floor_q <= (dir_q == DIR_UP) ? floor_q + 1'b1 : floor_q - 1'b1;
          run_q <= 1'b0;
          state_q <= ARRIVE;
        end
        OPEN: if (endOpen) begin
          open_q <= 1'b0;
          state_q <= ARRIVE;
        end
      endcase
    end
  end
`ifdef HOME_RETURN_EN
  logic [7:0] idle_cnt_q;
  logic idle_run, home_hit;
  assign idle_run = state_q == IDLE && pending == '0 && floor_q != FW'(HOME_FLOOR);
  assign home_hit = idle_run && idle_cnt_q == 8'(IDLE_TIMEOUT - 1);
  assign home_set = home_hit ? floor_bit(FW'(HOME_FLOOR)) : '0;
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) idle_cnt_q <= '0;
    else idle_cnt_q <= (idle_run && !home_hit) ? idle_cnt_q + 8'd1 : 8'd0;
  end
`else
  assign home_set = '0;
`endif
  assign StRun = run_q;
  assign StOpen = open_q;
  assign floor = floor_q;
  assign dir_up = dir_q[0];
  assign dir_dn = dir_q[1];
endmodule

// File: tb/tb_elevator_sequencer.sv
// tb_elevator_sequencer: directed scenarios checked against a per-cycle behavioural elevator model.
module tb_elevator_sequencer;
  logic CP = 1'b0;
  logic nCR = 1'b1;
  logic [3:0] call_req = '0;
  logic endRun = 1'b0;
  logic endOpen = 1'b0;
  logic StRun, StOpen, dir_up, dir_dn;
  logic [1:0] floor;
  logic [3:0] pending;
  int n_cmp = 0;
  int n_bad = 0;

  elevator_sequencer dut (
    .CP(CP), .nCR(nCR), .call_req(call_req), .endRun(endRun), .endOpen(endOpen),
    .StRun(StRun), .StOpen(StOpen), .floor(floor), .dir_up(dir_up), .dir_dn(dir_dn),
    .pending(pending)
  );

  initial forever #5 CP = ~CP;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: car position, direction as -1/0/+1, and which command (if any) is being held
  int m_floor = 0, m_dir = 0, m_idle = 0;
  bit m_run = 0, m_open = 0, m_pause = 0;
  logic [3:0] m_pend = '0;

  function automatic bit calls_toward(input logic [3:0] p, input int f, input int d);
    for (int i = 0; i < 4; i++) if (p[i] && (i - f) * d > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_dir = 0; m_idle = 0;
    m_run = 0; m_open = 0; m_pause = 0; m_pend = '0;
  endtask

  task automatic model_step();
    logic [3:0] np;
    int fwd;
    bit was_idle;
    was_idle = !m_run && !m_open && !m_pause;
    np = m_pend | call_req;
`ifdef HOME_RETURN_EN
    if (was_idle && m_pend == 0 && m_floor != elevator_sequencer_pkg::HOME_FLOOR) begin
      m_idle++;
      if (m_idle == elevator_sequencer_pkg::IDLE_TIMEOUT) begin
        np[elevator_sequencer_pkg::HOME_FLOOR] = 1'b1;
        m_idle = 0;
      end
    end else m_idle = 0;
`else
    if (was_idle) m_idle = 0;
`endif
    if (m_open) begin
      np[m_floor] = 1'b0;
      if (endOpen) begin m_open = 0; m_pause = 1; end
    end else if (m_run) begin
      if (endRun) begin m_floor += m_dir; m_run = 0; m_pause = 1; end
    end else begin
      m_pause = 0;
      fwd = (m_dir < 0) ? -1 : 1;
      if (m_pend[m_floor]) begin m_open = 1; np[m_floor] = 1'b0; end
      else if (calls_toward(m_pend, m_floor, fwd)) begin m_dir = fwd; m_run = 1; end
      else if (calls_toward(m_pend, m_floor, -fwd)) begin m_dir = -fwd; m_run = 1; end
      else m_dir = 0;
    end
    m_pend = np;
  endtask

  always @(posedge CP or negedge nCR) begin
    if (!nCR) model_reset();
    else model_step();
    #1;
    chk("m_StRun", StRun, m_run);
    chk("m_StOpen", StOpen, m_open);
    chk("m_floor", floor, m_floor);
    chk("m_dir_up", dir_up, m_dir > 0);
    chk("m_dir_dn", dir_dn, m_dir < 0);
    chk("m_pending", pending, m_pend);
    chk("both_cmds", StRun & StOpen, 0);
  end

  task automatic wait_hi(input bit door, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((door ? StOpen : StRun) === 1'b1) break;
      @(negedge CP);
    end
    chk(door ? "wait_StOpen" : "wait_StRun", door ? StOpen : StRun, 1);
  endtask

  task automatic call(input logic [3:0] v);
    call_req = v;
    @(negedge CP);
    call_req = '0;
  endtask

  task automatic run_step();
    wait_hi(1'b0, 20);
    repeat (2) @(negedge CP);
    endRun = 1'b1;
    @(negedge CP);
    endRun = 1'b0;
    chk("run_drop", StRun, 0);
  endtask

  task automatic open_step();
    wait_hi(1'b1, 20);
    @(negedge CP);
    endOpen = 1'b1;
    @(negedge CP);
    endOpen = 1'b0;
    chk("open_drop", StOpen, 0);
  endtask

  initial begin
    #2 nCR = 1'b0;
    @(negedge CP);
    chk("rst_cmds", {StRun, StOpen, dir_up, dir_dn}, 0);
    chk("rst_floor", floor, 0);
    chk("rst_pending", pending, 0);
    nCR = 1'b1;
    @(negedge CP);
    // 1: call at current floor opens two edges after it is driven
    call_req = 4'b0001;
    @(negedge CP);
    call_req = '0;
    chk("t1_latched", pending, 4'b0001);
    chk("t1_not_yet", StOpen, 0);
    @(negedge CP);
    chk("t1_open", StOpen, 1);
    chk("t1_cleared", pending, 0);
    open_step();
    // 2: travel 0 -> 3
    call(4'b1000);
    run_step(); chk("t2_f1", floor, 1); chk("t2_up", dir_up, 1);
    run_step(); chk("t2_f2", floor, 2);
    run_step(); chk("t2_f3", floor, 3);
    open_step();
    repeat (2) @(negedge CP);
    chk("t2_idle_dir", {dir_up, dir_dn}, 0);
    // 3: reposition to 0, then from floor 1 going up serve 3 before 0
    call(4'b0001);
    repeat (3) run_step();
    open_step();
    chk("t3_home", floor, 0);
    call(4'b0010);
    run_step();
    wait_hi(1'b1, 20);
    chk("t3_f1_up", dir_up, 1);
    call(4'b1001);
    chk("t3_pend", pending, 4'b1001);
    open_step();
    run_step(); run_step();
    chk("t3_f3", floor, 3);
    open_step();
    wait_hi(1'b0, 20);
    chk("t3_rev", {dir_up, dir_dn}, 2'b01);
    repeat (3) run_step();
    chk("t3_f0", floor, 0);
    open_step();
    repeat (2) @(negedge CP);
    chk("t3_dirs_clear", {dir_up, dir_dn}, 0);
    // 4: held call at the open floor is absorbed; stray endRun ignored
    call_req = 4'b0001;
    wait_hi(1'b1, 20);
    chk("t4_absorb", pending, 0);
    repeat (2) @(negedge CP);
    endRun = 1'b1;
    @(negedge CP);
    endRun = 1'b0;
    chk("t4_floor", floor, 0);
    chk("t4_still_open", StOpen, 1);
    chk("t4_no_run", StRun, 0);
    call_req = '0;
    @(negedge CP);
    endOpen = 1'b1;
    @(negedge CP);
    endOpen = 1'b0;
    repeat (3) @(negedge CP);
    chk("t4_no_reopen", StOpen, 0);
    chk("t4_pend", pending, 0);
    // 5: reset while running up from floor 2
    call(4'b1000);
    run_step(); run_step();
    wait_hi(1'b0, 20);
    nCR = 1'b0;
    #1;
    chk("t5_run_drop", StRun, 0);
    chk("t5_floor", floor, 0);
    chk("t5_pend", pending, 0);
    @(negedge CP);
    nCR = 1'b1;
    @(negedge CP);
    call(4'b0100);
    run_step(); run_step();
    chk("t5_f2", floor, 2);
    open_step();
`ifdef HOME_RETURN_EN
    // 6: idle away from home eventually returns there
    wait_hi(1'b0, elevator_sequencer_pkg::IDLE_TIMEOUT + 10);
    chk("t6_dn", dir_dn, 1);
    run_step(); run_step();
    chk("t6_home", floor, 0);
    open_step();
`endif
    repeat (3) @(negedge CP);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
